e203_tcm_sram_ctrl: RTL and testbench
=====================================

E203_TCM_SRAM_CTRL -- requirements
Module: e203_tcm_sram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 14, meaning SRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; MW = DW/8 is the byte-mask width.
REQ-003 SHALL have parameter IDLE_CYC, default 16, meaning the number of idle cycles before light-sleep entry (range 1..255).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  clock; rst_n  input  1  reset.
REQ-005 SHALL have i_icb_cmd_valid  input  1  command valid; i_icb_cmd_ready  output  1  command ready.
REQ-006 SHALL have i_icb_cmd_addr  input  AW+2  byte address; i_icb_cmd_read  input  1  1=read, 0=write.
REQ-007 SHALL have i_icb_cmd_wdata  input  DW  write data; i_icb_cmd_wmask  input  MW  byte enables.
REQ-008 SHALL have i_icb_rsp_valid  output  1  response valid; i_icb_rsp_ready  input  1  response ready.
REQ-009 SHALL have i_icb_rsp_rdata  output  DW  read data; i_icb_rsp_err  output  1  error, constant 0.
REQ-010 SHALL have ram_cs  output  1  chip select; ram_we  output  1  write enable; ram_addr  output  AW  word address.
REQ-011 SHALL have ram_wem  output  MW  write mask; ram_din  output  DW  write data; ram_dout  input  DW  read data.
REQ-012 SHALL have ram_ls  output  1  light sleep; ram_ds  output  1  deep sleep, constant 0; ram_sd  output  1  shutdown, constant 0.

Function
REQ-013 SHALL issue an SRAM access in the cycle the command handshake completes (cmd_valid & cmd_ready): ram_cs=1, ram_we=~read, ram_addr=cmd_addr[AW+1:2], ram_wem=wmask, ram_din=wdata.
REQ-014 SHALL drive ram_cs=0 in every cycle without a handshake; ram_addr, ram_wem and ram_din are don't-care when ram_cs=0.
REQ-015 SHALL treat SRAM read latency as exactly 1 cycle: ram_dout is valid in the cycle after cs&~we.
REQ-016 SHALL track one in-flight stage: a flag set on handshake, carrying the read/write type, and cleared the next cycle.
REQ-017 SHALL push every completed access into a 2-entry response FIFO: read entries hold ram_dout, write entries hold 0.
REQ-018 SHALL present the FIFO head on i_icb_rsp_*; pop on rsp_valid & rsp_ready.
REQ-019 SHALL assert cmd_ready only when in ACTIVE state and (inflight + occupancy - pop_this_cycle) < 2, so the FIFO never overflows.
REQ-020 SHALL permit push and pop in the same cycle with a FIFO full at entry; occupancy then stays unchanged.
REQ-021 SHALL sustain one command per cycle when rsp_ready is held at 1; the response appears 1 cycle after the command.
REQ-022 SHALL complete responses in command order.
REQ-023 SHALL implement an FSM with states ACTIVE and SLEEP:
- ACTIVE: the idle counter increments on cycles with no handshake, no in-flight access and an empty FIFO, and clears otherwise; when it reaches IDLE_CYC the FSM goes to SLEEP.
- SLEEP: ram_ls=1 and cmd_ready=0; on cmd_valid=1 the FSM goes to ACTIVE and the counter clears, so the command is accepted at the earliest on the following cycle.
REQ-024 SHALL hold the idle counter saturated, with no wrap, at IDLE_CYC.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously clear the state to ACTIVE, the counter to 0, the in-flight flag to 0 and the FIFO pointers to 0.
REQ-026 SHALL hold these outputs in reset: cmd_ready=0, rsp_valid=0, ram_cs=0, ram_ls=0.
REQ-027 SHALL discard any in-flight access or queued response when reset is asserted mid-operation; no response is issued after reset deassertion.

Structure
REQ-028 SHALL place the FSM state encoding and the default AW/DW/IDLE_CYC values in the shared e203 defines package, as E203_TCM_CTRL_* constants.
REQ-029 SHALL implement the response FIFO as a sub-module e203_tcm_rsp_fifo (DP=2, width DW), with no other sub-modules.

Verification
REQ-030 Back-to-back test: write 0xDEADBEEF with mask 0xF to addr 0x10, then read addr 0x10, with rsp_ready=1 -> ram_addr=4 both cycles; write response next cycle; read response rdata=0xDEADBEEF one cycle after the read command.
REQ-031 Partial-mask test: preload 0x11223344, write 0xAABBCCDD with mask 0x3, then read -> rdata=0x1122CCDD.
REQ-032 Backpressure test: rsp_ready=0 with 3 read commands offered -> exactly 2 accepted and cmd_ready=0 afterwards; when rsp_ready is raised, 2 in-order responses are returned and the third command is accepted in that same pop cycle.
REQ-033 Sleep test: 16 idle cycles -> ram_ls=1; then cmd_valid=1 -> cmd_ready=0 for 1 cycle, ram_ls=0 next cycle, command accepted, response correct.
REQ-034 Reset test: assert rst_n=0 while a read is in flight -> rsp_valid=0 and ram_cs=0 immediately, and no stray response appears after release.

Source files
------------

// File: rtl/e203_tcm_sram_ctrl_pkg.sv
// Shared defines for the E203 TCM SRAM controller: default geometry,
// light-sleep timing and the power-state encoding.
package e203_tcm_sram_ctrl_pkg;

    localparam int E203_TCM_CTRL_AW       = 14;
    localparam int E203_TCM_CTRL_DW       = 32;
    localparam int E203_TCM_CTRL_IDLE_CYC = 16;
    localparam int E203_TCM_CTRL_IDLE_CW  = 8;

    typedef enum logic {
        E203_TCM_CTRL_ACTIVE = 1'b0,
        E203_TCM_CTRL_SLEEP  = 1'b1
    } e203_tcm_ctrl_state_e;

endpackage

// File: rtl/e203_tcm_rsp_fifo.sv
// Response FIFO with fall-through: when empty, the incoming entry is visible
// on the output in the same cycle and is only stored if it is not popped.
module e203_tcm_rsp_fifo #(
    parameter int  DP = 2,
    parameter int  DW = 32,
    localparam int PW = (DP > 1) ? $clog2(DP) : 1,
    localparam int CW = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [DW-1:0] o_rdata,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DP];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_store;
    logic          w_take;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_store = i_push & ~(w_empty & i_pop);
    assign w_take  = i_pop & ~w_empty;
    assign o_valid = ~w_empty | i_push;
    assign o_rdata = w_empty ? i_wdata : r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DP; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_store) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= nxt_ptr(r_wptr);
            end
            if (w_take) begin
                r_rptr <= nxt_ptr(r_rptr);
            end
            r_count <= r_count + CW'(w_store) - CW'(w_take);
        end
    end

endmodule

// File: rtl/e203_tcm_sram_ctrl.sv
// ICB-to-SRAM bridge for the E203 TCM: single-cycle SRAM issue, two-deep
// in-order response queue and automatic light-sleep after an idle period.
module e203_tcm_sram_ctrl
    import e203_tcm_sram_ctrl_pkg::*;
#(
    parameter int  AW       = E203_TCM_CTRL_AW,
    parameter int  DW       = E203_TCM_CTRL_DW,
    parameter int  IDLE_CYC = E203_TCM_CTRL_IDLE_CYC,
    localparam int MW       = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_icb_cmd_valid,
    output logic          i_icb_cmd_ready,
    input  logic [AW+1:0] i_icb_cmd_addr,
    input  logic          i_icb_cmd_read,
    input  logic [DW-1:0] i_icb_cmd_wdata,
    input  logic [MW-1:0] i_icb_cmd_wmask,
    output logic          i_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic [DW-1:0] i_icb_rsp_rdata,
    output logic          i_icb_rsp_err,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    localparam int FIFO_DP = 2;
    localparam int CNT_W   = $clog2(FIFO_DP + 1);
    localparam int PEND_W  = CNT_W + 1;
    localparam int IW      = E203_TCM_CTRL_IDLE_CW;

    e203_tcm_ctrl_state_e r_state;
    logic [IW-1:0]        r_idle_cnt;
    logic                 r_inflight;
    logic                 r_inflight_read;
    logic [CNT_W-1:0]     w_fifo_cnt;
    logic [PEND_W-1:0]    w_pending;
    logic [DW-1:0]        w_fifo_wdata;
    logic                 w_hsk;
    logic                 w_pop;
    logic                 w_idle;
    logic                 w_unused;

    // Outstanding work after this cycle's pop must leave room for one more entry.
    assign w_pending       = PEND_W'(r_inflight) + PEND_W'(w_fifo_cnt) - PEND_W'(w_pop);
    assign i_icb_cmd_ready = rst_n & (r_state == E203_TCM_CTRL_ACTIVE) & (w_pending < PEND_W'(2));
    assign w_hsk           = i_icb_cmd_valid & i_icb_cmd_ready;
    assign w_pop           = i_icb_rsp_valid & i_icb_rsp_ready;
    assign w_idle          = ~w_hsk & ~r_inflight & (w_fifo_cnt == '0);

    assign ram_cs   = w_hsk;
    assign ram_we   = ~i_icb_cmd_read;
    assign ram_addr = i_icb_cmd_addr[AW+1:2];
    assign ram_wem  = i_icb_cmd_wmask;
    assign ram_din  = i_icb_cmd_wdata;
    assign ram_ls   = (r_state == E203_TCM_CTRL_SLEEP);
    assign ram_ds   = 1'b0;
    assign ram_sd   = 1'b0;

    assign i_icb_rsp_err = 1'b0;
    assign w_fifo_wdata  = r_inflight_read ? ram_dout : '0;
    assign w_unused      = ^i_icb_cmd_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= E203_TCM_CTRL_ACTIVE;
            r_idle_cnt      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_read <= 1'b0;
        end else begin
            r_inflight <= w_hsk;
            if (w_hsk) begin
                r_inflight_read <= i_icb_cmd_read;
            end
            case (r_state)
                E203_TCM_CTRL_ACTIVE: begin
                    if (!w_idle) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt >= IW'(IDLE_CYC - 1)) begin
                        r_state    <= E203_TCM_CTRL_SLEEP;
                        r_idle_cnt <= IW'(IDLE_CYC);
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IW'(1);
                    end
                end
                E203_TCM_CTRL_SLEEP: begin
                    // Wake only; the command itself is taken on the next cycle.
                    if (i_icb_cmd_valid) begin
                        r_state    <= E203_TCM_CTRL_ACTIVE;
                        r_idle_cnt <= '0;
                    end
                end
            endcase
        end
    end

    e203_tcm_rsp_fifo #(
        .DP (FIFO_DP),
        .DW (DW)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_valid (i_icb_rsp_valid),
        .o_rdata (i_icb_rsp_rdata),
        .o_count (w_fifo_cnt)
    );

endmodule

// File: tb/tb_e203_tcm_sram_ctrl.sv
// Directed and randomized bench for e203_tcm_sram_ctrl with an SRAM model
// and a transaction-level scoreboard of expected responses and sleep state.
module tb_e203_tcm_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmdValid;
    logic        cmdReady;
    logic [15:0] cmdAddr;
    logic        cmdRead;
    logic [31:0] cmdWdata;
    logic [3:0]  cmdWmask;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic        ramCs;
    logic        ramWe;
    logic [13:0] ramAddr;
    logic [3:0]  ramWem;
    logic [31:0] ramDin;
    logic [31:0] ramDout = '0;
    logic        ramLs;
    logic        ramDs;
    logic        ramSd;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram    [0:16383];
    logic [31:0] goldMem [0:16383];
    logic [31:0] expQ [$];
    bit          sleeping = 1'b0;
    int          idleRun  = 0;
    int          qBefore;
    int          wordIdx;
    bit          expValid;
    bit          expPop;
    bit          expReady;
    bit          hsk;

    always #5 clk = ~clk;

    e203_tcm_sram_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_icb_cmd_valid (cmdValid),
        .i_icb_cmd_ready (cmdReady),
        .i_icb_cmd_addr  (cmdAddr),
        .i_icb_cmd_read  (cmdRead),
        .i_icb_cmd_wdata (cmdWdata),
        .i_icb_cmd_wmask (cmdWmask),
        .i_icb_rsp_valid (rspValid),
        .i_icb_rsp_ready (rspReady),
        .i_icb_rsp_rdata (rspRdata),
        .i_icb_rsp_err   (rspErr),
        .ram_cs          (ramCs),
        .ram_we          (ramWe),
        .ram_addr        (ramAddr),
        .ram_wem         (ramWem),
        .ram_din         (ramDin),
        .ram_dout        (ramDout),
        .ram_ls          (ramLs),
        .ram_ds          (ramDs),
        .ram_sd          (ramSd)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit rd, input logic [15:0] a,
                                 input logic [31:0] wd, input logic [3:0] wm, input bit rr);
        cmdValid = v;
        cmdRead  = rd;
        cmdAddr  = a;
        cmdWdata = wd;
        cmdWmask = wm;
        rspReady = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SRAM model: byte-masked writes, one-cycle read latency.
    always @(posedge clk) begin
        if (ramCs) begin
            if (ramWe) begin
                for (int b = 0; b < 4; b++) begin
                    if (ramWem[b]) sram[ramAddr][b*8 +: 8] = ramDin[b*8 +: 8];
                end
            end else begin
                ramDout <= sram[ramAddr];
            end
        end
    end

    // Scoreboard: every accepted command owes one in-order response; readiness
    // follows the outstanding count and the sleep state derived from idle time.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rstCmdReady", cmdReady, 0);
            checkOutput("rstRspValid", rspValid, 0);
            checkOutput("rstRamCs", ramCs, 0);
            checkOutput("rstRamLs", ramLs, 0);
            expQ.delete();
            sleeping = 1'b0;
            idleRun  = 0;
        end else begin
            qBefore  = expQ.size();
            expValid = (qBefore > 0);
            expPop   = expValid && rspReady;
            expReady = !sleeping && ((qBefore - int'(expPop)) < 2);
            checkOutput("cmdReady", cmdReady, expReady);
            checkOutput("rspValid", rspValid, expValid);
            checkOutput("ramLs", ramLs, sleeping);
            checkOutput("ramCs", ramCs, cmdValid && expReady);
            checkOutput("tieOffs", {rspErr, ramDs, ramSd}, 0);
            if (rspValid && rspReady && qBefore > 0) begin
                checkOutput("rspRdata", rspRdata, expQ[0]);
                void'(expQ.pop_front());
            end
            hsk = cmdValid && cmdReady;
            if (hsk) begin
                wordIdx = int'(cmdAddr[15:2]);
                checkOutput("ramAddr", ramAddr, cmdAddr[15:2]);
                checkOutput("ramWe", ramWe, !cmdRead);
                if (cmdRead) begin
                    expQ.push_back(goldMem[wordIdx]);
                end else begin
                    checkOutput("ramWem", ramWem, cmdWmask);
                    checkOutput("ramDin", ramDin, cmdWdata);
                    for (int b = 0; b < 4; b++) begin
                        if (cmdWmask[b]) goldMem[wordIdx][b*8 +: 8] = cmdWdata[b*8 +: 8];
                    end
                    expQ.push_back(32'h0);
                end
            end
            if (sleeping) begin
                if (cmdValid) begin
                    sleeping = 1'b0;
                    idleRun  = 0;
                end
            end else if (!hsk && qBefore == 0) begin
                idleRun++;
                if (idleRun >= 16) sleeping = 1'b1;
            end else begin
                idleRun = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            sram[i]    = '0;
            goldMem[i] = '0;
        end
        rst_n = 1'b0;
        applyStimulus(0, 0, 16'h0, 32'h0, 4'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetReady", cmdReady, 0);
        checkOutput("resetRspValid", rspValid, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] back-to-back write/read");
        applyStimulus(1, 0, 16'h0010, 32'hDEADBEEF, 4'hF, 1);
        @(negedge clk);
        checkOutput("b2bWrCs", ramCs, 1);
        checkOutput("b2bWrAddr", ramAddr, 14'd4);
        tick();
        applyStimulus(1, 1, 16'h0010, 32'h0, 4'h0, 1);
        @(negedge clk);
        checkOutput("b2bRdAddr", ramAddr, 14'd4);
        checkOutput("b2bWrRspValid", rspValid, 1);
        checkOutput("b2bWrRspData", rspRdata, 32'h0);
        tick();
        applyStimulus(0, 0, 16'h0, 32'h0, 4'h0, 1);
        @(negedge clk);
        checkOutput("b2bRdRspValid", rspValid, 1);
        checkOutput("b2bRdRspData", rspRdata, 32'hDEADBEEF);
        tick();

        $display("[TB] partial mask");
        applyStimulus(1, 0, 16'h0020, 32'h11223344, 4'hF, 1);
        tick();
        applyStimulus(1, 0, 16'h0020, 32'hAABBCCDD, 4'h3, 1);
        tick();
        applyStimulus(1, 1, 16'h0020, 32'h0, 4'h0, 1);
        tick();
        applyStimulus(0, 0, 16'h0, 32'h0, 4'h0, 1);
        @(negedge clk);
        checkOutput("maskRdata", rspRdata, 32'h1122CCDD);
        tick();

        $display("[TB] backpressure");
        applyStimulus(1, 1, 16'h0010, 32'h0, 4'h0, 0);
        @(negedge clk);
        checkOutput("bpAcceptA", cmdReady, 1);
        tick();
        applyStimulus(1, 1, 16'h0020, 32'h0, 4'h0, 0);
        @(negedge clk);
        checkOutput("bpAcceptB", cmdReady, 1);
        tick();
        applyStimulus(1, 1, 16'h0010, 32'h0, 4'h0, 0);
        @(negedge clk);
        checkOutput("bpStallC1", cmdReady, 0);
        tick();
        @(negedge clk);
        checkOutput("bpStallC2", cmdReady, 0);
        checkOutput("bpHeldValid", rspValid, 1);
        tick();
        applyStimulus(1, 1, 16'h0010, 32'h0, 4'h0, 1);
        @(negedge clk);
        checkOutput("bpAcceptOnPop", cmdReady, 1);
        checkOutput("bpRspA", rspRdata, 32'hDEADBEEF);
        tick();
        applyStimulus(0, 0, 16'h0, 32'h0, 4'h0, 1);
        @(negedge clk);
        checkOutput("bpRspB", rspRdata, 32'h1122CCDD);
        tick();
        @(negedge clk);
        checkOutput("bpRspC", rspRdata, 32'hDEADBEEF);
        tick();

        $display("[TB] light sleep");
        repeat (15) tick();
        @(negedge clk);
        checkOutput("sleepNotYet", ramLs, 0);
        tick();
        @(negedge clk);
        checkOutput("sleepEntered", ramLs, 1);
        tick();
        applyStimulus(1, 1, 16'h0020, 32'h0, 4'h0, 1);
        @(negedge clk);
        checkOutput("wakeReadyLow", cmdReady, 0);
        tick();
        @(negedge clk);
        checkOutput("wakeLsLow", ramLs, 0);
        checkOutput("wakeAccept", cmdReady, 1);
        tick();
        applyStimulus(0, 0, 16'h0, 32'h0, 4'h0, 1);
        @(negedge clk);
        checkOutput("wakeRspData", rspRdata, 32'h1122CCDD);
        tick();

        $display("[TB] reset while read in flight");
        applyStimulus(1, 1, 16'h0010, 32'h0, 4'h0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midRstRspValid", rspValid, 0);
        checkOutput("midRstRamCs", ramCs, 0);
        tick();
        tick();
        applyStimulus(0, 0, 16'h0, 32'h0, 4'h0, 1);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("noStrayRsp", rspValid, 0);
            tick();
        end

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                          16'($urandom_range(0, 15) << 2) | 16'($urandom_range(0, 3)),
                          $urandom, 4'($urandom), $urandom_range(0, 9) < 6);
            tick();
        end
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                          16'($urandom_range(0, 15) << 2),
                          $urandom, 4'($urandom), $urandom_range(0, 3) != 0);
            tick();
        end

        applyStimulus(0, 0, 16'h0, 32'h0, 4'h0, 1);
        for (int n = 0; n < 20 && expQ.size() > 0; n++) tick();
        checkOutput("drainEmpty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
